menu_select_ctrl: RTL

//  Parametrised menu/start controller: hit-tests the mouse against N_BTN rectangular buttons,

---
 rtl/menu_pkg.sv | 14 +
 rtl/menu_select_ctrl_if.sv | 13 +
 rtl/rect_hit.sv | 12 +
 rtl/menu_select_ctrl.sv | 105 ++++++++++
 4 files changed

// File: rtl/menu_pkg.sv
// menu_pkg: shared state encodings, default button rectangles and a clog2 helper
package menu_pkg;
  typedef enum logic [1:0] {ST_IDLE, ST_PRESS, ST_WAIT, ST_RUN} state_t;
  localparam logic [23:0] DEF_BTN_X0 = {12'd490, 12'd490};
  localparam logic [23:0] DEF_BTN_X1 = {12'd530, 12'd530};
  localparam logic [23:0] DEF_BTN_Y0 = {12'd630, 12'd600};
  localparam logic [23:0] DEF_BTN_Y1 = {12'd645, 12'd615};
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction
endpackage

// File: rtl/menu_select_ctrl_if.sv
// menu_select_ctrl_if: mouse inputs, game_over and the start/selection outputs of the menu controller
interface menu_select_ctrl_if #(parameter int N_BTN = 2, parameter int SEL_W = 1);
  logic [11:0] mouse_xpos;
  logic [11:0] mouse_ypos;
  logic mouse_left;
  logic game_over;
  logic start_en;
  logic [SEL_W-1:0] mode_sel;
  logic busy;
  logic [N_BTN-1:0] hover;
  modport master (output mouse_xpos, mouse_ypos, mouse_left, game_over, input start_en, mode_sel, busy, hover);
  modport slave (input mouse_xpos, mouse_ypos, mouse_left, game_over, output start_en, mode_sel, busy, hover);
endinterface

// File: rtl/rect_hit.sv
// rect_hit: pointer-inside test against one rectangle, all bounds inclusive
module rect_hit (
  input  logic [11:0] x,
  input  logic [11:0] y,
  input  logic [11:0] x0,
  input  logic [11:0] x1,
  input  logic [11:0] y0,
  input  logic [11:0] y1,
  output logic hit
);
  assign hit = (x >= x0) && (x <= x1) && (y >= y0) && (y <= y1);
endmodule

// File: rtl/menu_select_ctrl.sv
// menu_select_ctrl: click-confirmed button select, delay, then start_en until game_over (optional MENU_HOVER_EN hover flags)
module menu_select_ctrl import menu_pkg::*; #(
  parameter int N_BTN = 2,
  parameter int DELAY_CYCLES = 75_000_000,
  parameter int CNT_W = 27,
  parameter int SEL_W = 1,
  parameter logic [12*N_BTN-1:0] BTN_X0 = DEF_BTN_X0,
  parameter logic [12*N_BTN-1:0] BTN_X1 = DEF_BTN_X1,
  parameter logic [12*N_BTN-1:0] BTN_Y0 = DEF_BTN_Y0,
  parameter logic [12*N_BTN-1:0] BTN_Y1 = DEF_BTN_Y1
) (
  input logic pclk,
  input logic rst,
  menu_select_ctrl_if.slave bus
);
  state_t state, state_n;
  logic [SEL_W-1:0] sel, sel_n, hit_idx;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic ml_q, start_q, busy_q, press, rel, any_hit, sel_hit;
  logic [N_BTN-1:0] hit, hit_sh;
  for (genvar k = 0; k < N_BTN; k++) begin : g_btn
    rect_hit u_hit (
      .x(bus.mouse_xpos), .y(bus.mouse_ypos),
      .x0(BTN_X0[12*k +: 12]), .x1(BTN_X1[12*k +: 12]),
      .y0(BTN_Y0[12*k +: 12]), .y1(BTN_Y1[12*k +: 12]),
      .hit(hit[k])
    );
  end
  assign press = bus.mouse_left & ~ml_q;
  assign rel = ~bus.mouse_left & ml_q;
  assign any_hit = |hit;
  assign hit_sh = hit >> sel;
  assign sel_hit = hit_sh[0];
  // lowest-index button under the pointer wins on overlap
  always_comb begin
    hit_idx = '0;
    for (int k = N_BTN - 1; k >= 0; k--) if (hit[k]) hit_idx = SEL_W'(k);
  end
  // next state, selection and delay counter; a cancel press beats expiry
  always_comb begin
    state_n = state;
    sel_n = sel;
    cnt_n = cnt;
    case (state)
      ST_IDLE: if (press && any_hit) begin
        state_n = ST_PRESS;
        sel_n = hit_idx;
      end
      ST_PRESS: if (rel) begin
        state_n = sel_hit ? ST_WAIT : ST_IDLE;
        sel_n = sel_hit ? sel : '0;
        cnt_n = '0;
      end
      ST_WAIT: if (press && sel_hit) begin
        state_n = ST_IDLE;
        sel_n = '0;
        cnt_n = '0;
      end else if (cnt == CNT_W'(DELAY_CYCLES - 1)) begin
        state_n = ST_RUN;
        cnt_n = '0;
      end else cnt_n = cnt + 1'b1;
      ST_RUN: if (bus.game_over) begin
        state_n = ST_IDLE;
        sel_n = '0;
      end
      default: begin
        state_n = ST_IDLE;
        sel_n = '0;
        cnt_n = '0;
      end
    endcase
  end
  // state and registered outputs, which track the state being entered
  always_ff @(posedge pclk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
      sel <= '0;
      cnt <= '0;
      ml_q <= 1'b0;
      start_q <= 1'b0;
      busy_q <= 1'b0;
    end else begin
      state <= state_n;
      sel <= sel_n;
      cnt <= cnt_n;
      ml_q <= bus.mouse_left;
      start_q <= state_n == ST_RUN;
      busy_q <= state_n == ST_WAIT;
    end
  end
  assign bus.start_en = start_q;
  assign bus.busy = busy_q;
  assign bus.mode_sel = sel;
`ifdef MENU_HOVER_EN
  logic [N_BTN-1:0] hover_q;
  // per-button hover flags, one cycle behind the pointer, in every state
  always_ff @(posedge pclk or posedge rst) begin
    if (rst) hover_q <= '0;
    else hover_q <= hit;
  end
  assign bus.hover = hover_q;
`else
  assign bus.hover = '0;
`endif
endmodule
